mem_port_arbiter: RTL and testbench

Arbitrates and sequences one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the five-stage pipeline. Each request is latched, driven to the memory for a fixed number of wait cycles, and completed with a one-cycle ready pulse. Stall outputs feed the pipeline freeze logic, alongside the hazard freeze. In-flight accesses are never aborted.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals
// of the shared single-port memory arbiter.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_rd_en;
   logic        d_wr_en;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  d_rd_en, d_wr_en, d_addr, d_wdata,
      input  mem_rdata,
      output if_ready, if_rdata, if_stall,
      output d_ready, d_rdata, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output d_rd_en, d_wr_en, d_addr, d_wdata,
      output mem_rdata,
      input  if_ready, if_rdata, if_stall,
      input  d_ready, d_rdata, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between
// fetch and load/store, alternating on contention.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  cnt;
   logic        last_d;
   logic        gnt_d;
   logic        wr;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        if_ready_q;
   logic        d_ready_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;
   logic        mem_en_q;
   logic        mem_we_q;

   logic        d_req;
   logic        grant;
   logic        grant_d;
   logic        grant_wr;
   logic        last_cyc;

   assign d_req = bus.d_rd_en | bus.d_wr_en;

   // Next state, grant choice and end-of-access detection
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_d  = 1'b0;
      grant_wr = 1'b0;
      last_cyc = 1'b0;
      case (state)
         IDLE: begin
            if (bus.if_req || d_req) begin
               grant    = 1'b1;
               state_nx = ACCESS;
               if (bus.if_req && d_req)
                  grant_d = ~last_d;
               else
                  grant_d = d_req;
               grant_wr = grant_d & bus.d_wr_en;
            end
         end
         ACCESS: begin
            if (cnt == LAST) begin
               last_cyc = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Access cycle counter, cleared on grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= 4'd0;
      else if (grant)
         cnt <= 4'd0;
      else if (state == ACCESS)
         cnt <= cnt + 4'd1;
   end

   // Latch requester, address, write flag and store data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_d   <= 1'b0;
         wr      <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else if (grant) begin
         gnt_d   <= grant_d;
         wr      <= grant_wr;
         addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
         wdata_q <= grant_wr ? bus.d_wdata : 32'd0;
      end
   end

   // Remember who was served last for tie-breaking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_d <= 1'b0;
      else if (last_cyc)
         last_d <= gnt_d;
   end

   // Memory enable and write strobe, active for the access cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         mem_en_q <= (state_nx == ACCESS);
         mem_we_q <= (state_nx == ACCESS) &&
                     (grant ? grant_wr : wr);
      end
   end

   // One-cycle ready pulse to the granted requester
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
      end else begin
         if_ready_q <= last_cyc & ~gnt_d;
         d_ready_q  <= last_cyc & gnt_d;
      end
   end

   // Capture read data on the last access cycle; stores keep d_rdata
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else if (last_cyc) begin
         if (!gnt_d)
            if_rdata_q <= bus.mem_rdata;
         else if (!wr)
            d_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_stall  = bus.if_req & ~if_ready_q;
   assign bus.d_stall   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios, ready/rdata
// checked by a scoreboard monitor.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MEM_LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] mem_word(logic [31:0] a);
      case (a)
         32'h0000_0040: mem_word = 32'h1234_5678;
         32'h0000_0080: mem_word = 32'hCAFE_F00D;
         default:       mem_word = a ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   assign bus.mem_rdata = bus.mem_en ? mem_word(bus.mem_addr) : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(string nm, logic act, logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic push(bit is_d, logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic pop_chk(bit is_d, logic [31:0] rd);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL ready_unexpected: got is_d=%0d rdata %h want none",
                  is_d, rd);
      end else begin
         e = sb.pop_front();
         if (e.is_d != is_d || e.data !== rd) begin
            n_fail++;
            $display("FAIL ready_order: got is_d=%0d rdata %h want is_d=%0d rdata %h",
                     is_d, rd, e.is_d, e.data);
         end
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (bus.if_ready) pop_chk(1'b0, bus.if_rdata);
         if (bus.d_ready)  pop_chk(1'b1, bus.d_rdata);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.if_req  = 1'b0;
      bus.if_addr = 32'h0;
      bus.d_rd_en = 1'b0;
      bus.d_wr_en = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_in();
      cyc();
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_if_ready", bus.if_ready, 1'b0);
      chk1("rst_d_ready", bus.d_ready, 1'b0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
      cyc();
      rst = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      idle_in();

      // Reset state
      cyc();
      #1;
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk1("rst_if_stall", bus.if_stall, 1'b0);

      // Single fetch
      do_reset();
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      push(1'b0, 32'h1234_5678);
      #1;
      chk1("s1_c0_stall", bus.if_stall, 1'b1);
      chk1("s1_c0_en", bus.mem_en, 1'b0);
      cyc(); #1;
      chk1("s1_c1_en", bus.mem_en, 1'b1);
      chk("s1_c1_addr", bus.mem_addr, 32'h40);
      chk1("s1_c1_stall", bus.if_stall, 1'b1);
      cyc(); #1;
      chk1("s1_c2_en", bus.mem_en, 1'b1);
      chk1("s1_c2_stall", bus.if_stall, 1'b1);
      cyc(); #1;
      chk1("s1_c3_ready", bus.if_ready, 1'b1);
      chk1("s1_c3_en", bus.mem_en, 1'b0);
      chk1("s1_c3_stall", bus.if_stall, 1'b0);
      idle_in();
      repeat (3) cyc();

      // Tie after reset: data first
      do_reset();
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      bus.d_rd_en = 1'b1;
      bus.d_addr  = 32'h80;
      push(1'b1, 32'hCAFE_F00D);
      push(1'b0, 32'h1234_5678);
      cyc(); #1;
      chk("s2_c1_addr", bus.mem_addr, 32'h80);
      chk1("s2_c1_we", bus.mem_we, 1'b0);
      cyc(); #1;
      chk1("s2_c2_if_stall", bus.if_stall, 1'b1);
      cyc(); #1;
      chk1("s2_c3_d_ready", bus.d_ready, 1'b1);
      chk1("s2_c3_if_ready", bus.if_ready, 1'b0);
      chk1("s2_c3_d_stall", bus.d_stall, 1'b0);
      chk1("s2_c3_if_stall", bus.if_stall, 1'b1);
      bus.d_rd_en = 1'b0;
      cyc(); #1;
      chk1("s2_c4_en", bus.mem_en, 1'b0);
      cyc(); #1;
      chk1("s2_c5_en", bus.mem_en, 1'b1);
      chk("s2_c5_addr", bus.mem_addr, 32'h40);
      cyc(); #1;
      chk1("s2_c6_if_stall", bus.if_stall, 1'b1);
      cyc(); #1;
      chk1("s2_c7_if_ready", bus.if_ready, 1'b1);
      chk1("s2_c7_if_stall", bus.if_stall, 1'b0);
      idle_in();
      repeat (2) cyc();

      // Store (both enables high), d_rdata keeps last load
      cyc();
      bus.d_wr_en = 1'b1;
      bus.d_rd_en = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = 32'hDEAD_BEEF;
      push(1'b1, 32'hCAFE_F00D);
      for (int c = 1; c <= 2; c++) begin
         cyc(); #1;
         chk1("s3_en", bus.mem_en, 1'b1);
         chk1("s3_we", bus.mem_we, 1'b1);
         chk("s3_addr", bus.mem_addr, 32'h100);
         chk("s3_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      end
      cyc(); #1;
      chk1("s3_d_ready", bus.d_ready, 1'b1);
      chk1("s3_if_ready", bus.if_ready, 1'b0);
      chk1("s3_we_off", bus.mem_we, 1'b0);
      idle_in();
      repeat (2) cyc();

      // Continuous contention: D, I, D, I ...
      do_reset();
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0)
            push(1'b1, 32'hCAFE_F00D);
         else
            push(1'b0, 32'h1234_5678);
      end
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (c == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h40;
            bus.d_rd_en = 1'b1;
            bus.d_addr  = 32'h80;
         end
         #1;
         chk1("s4_d_ready", bus.d_ready,
              (c % 4 == 3) && ((c / 4) % 2 == 0));
         chk1("s4_if_ready", bus.if_ready,
              (c % 4 == 3) && ((c / 4) % 2 == 1));
         if (c == 39) idle_in();
      end
      repeat (2) cyc();

      // Dropped fetch still completes; new fetch waits
      do_reset();
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      push(1'b0, 32'h1234_5678);
      cyc();
      bus.if_req = 1'b0;
      #1;
      chk1("s5_c1_en", bus.mem_en, 1'b1);
      chk("s5_c1_addr", bus.mem_addr, 32'h40);
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      push(1'b0, 32'h5A5A_585A);
      #1;
      chk1("s5_c2_en", bus.mem_en, 1'b1);
      chk("s5_c2_addr", bus.mem_addr, 32'h40);
      cyc(); #1;
      chk1("s5_c3_ready", bus.if_ready, 1'b1);
      chk1("s5_c3_stall", bus.if_stall, 1'b0);
      cyc(); #1;
      chk1("s5_c4_en", bus.mem_en, 1'b0);
      cyc(); #1;
      chk1("s5_c5_en", bus.mem_en, 1'b1);
      chk("s5_c5_addr", bus.mem_addr, 32'h200);
      cyc(); cyc(); #1;
      chk1("s5_c7_ready", bus.if_ready, 1'b1);
      idle_in();
      repeat (2) cyc();

      // Mid-access reset, then a fresh fetch
      do_reset();
      cyc();
      bus.d_wr_en = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = 32'h1111_2222;
      cyc(); #1;
      chk1("s6_c1_en", bus.mem_en, 1'b1);
      chk1("s6_c1_we", bus.mem_we, 1'b1);
      chk1("s6_c1_d_stall", bus.d_stall, 1'b1);
      cyc();
      rst = 1'b0;
      #1;
      chk1("s6_rst_en", bus.mem_en, 1'b0);
      chk1("s6_rst_we", bus.mem_we, 1'b0);
      chk1("s6_rst_if_ready", bus.if_ready, 1'b0);
      chk1("s6_rst_d_ready", bus.d_ready, 1'b0);
      chk("s6_rst_addr", bus.mem_addr, 32'h0);
      idle_in();
      cyc();
      rst = 1'b1;
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      push(1'b0, 32'h1234_5678);
      begin
         int n;
         n = 0;
         do begin
            cyc(); #1;
            n++;
         end while (!bus.if_ready && n < 20);
         chk("s6_latency", 32'(n), 32'd3);
      end
      idle_in();
      repeat (3) cyc();

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
